// File: rtl/tlb_plru_alloc.sv
// Tree pseudo-LRU victim allocator for a TLB: multi-port hit touches, an
// invalid-first / tree-walk / unlocked-fallback victim choice, and an IDLE/GRANT refill handshake.

module tlb_plru_hit_dec #(
    parameter  int ENTRIES = 32,
    localparam int IDXW    = $clog2(ENTRIES)
) (
    input  logic               vld,
    input  logic [ENTRIES-1:0] vec,
    output logic               hit,
    output logic [IDXW-1:0]    idx
);
    // OR-encode is exact only for one-hot input; hit gates off the other cases
    always_comb begin
        idx = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (vec[i]) idx = idx | IDXW'(i);
    end

    assign hit = vld && (vec != '0) && ((vec & (vec - ENTRIES'(1))) == '0);
endmodule

module tlb_plru_alloc #(
    parameter  int ENTRIES   = 32,
    parameter  int HIT_PORTS = 2,
    localparam int IDXW      = $clog2(ENTRIES)
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic [ENTRIES-1:0]           entry_valid_i,
    input  logic [ENTRIES-1:0]           lock_i,
    input  logic [HIT_PORTS-1:0]         hit_vld_i,
    input  logic [HIT_PORTS*ENTRIES-1:0] hit_onehot_i,
    input  logic                         alloc_req_i,
    input  logic                         refill_done_i,
    output logic                         victim_vld_o,
    output logic [IDXW-1:0]              victim_idx_o,
    output logic [ENTRIES-1:0]           victim_onehot_o,
    output logic                         no_victim_o
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                          state;
    logic [ENTRIES-2:0]              tree, tree_nxt;
    logic [HIT_PORTS-1:0]            hit;
    logic [HIT_PORTS-1:0][IDXW-1:0]  hit_idx;
    logic [IDXW-1:0]                 walk_idx, sel_idx;
    logic [ENTRIES-1:0]              free, unlocked;
    logic                            any_unlocked;

    for (genvar p = 0; p < HIT_PORTS; p++) begin : g_port
        tlb_plru_hit_dec #(.ENTRIES(ENTRIES)) u_dec (
            .vld (hit_vld_i[p]),
            .vec (hit_onehot_i[p*ENTRIES +: ENTRIES]),
            .hit (hit[p]),
            .idx (hit_idx[p])
        );
    end

    // Heap-indexed walk: node k's children are 2k+1 / 2k+2; each node on e's path points away from e
    function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] t, input logic [IDXW-1:0] e);
        logic [ENTRIES-2:0] r;
        int k;
        r = t;
        k = 0;
        for (int l = 0; l < IDXW; l++) begin
            r[k] = ~e[IDXW-1-l];
            k    = 2*k + 1 + int'(e[IDXW-1-l]);
        end
        return r;
    endfunction

    function automatic logic [IDXW-1:0] lowest(input logic [ENTRIES-1:0] m);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = ENTRIES-1; i >= 0; i--)
            if (m[i]) r = IDXW'(i);
        return r;
    endfunction

    always_comb begin
        int k;
        k        = 0;
        walk_idx = '0;
        for (int l = 0; l < IDXW; l++) begin
            walk_idx[IDXW-1-l] = tree[k];
            k                  = 2*k + 1 + int'(tree[k]);
        end
    end

    assign free         = ~entry_valid_i & ~lock_i;
    assign unlocked     = ~lock_i;
    assign any_unlocked = |unlocked;

    always_comb begin
        if (|free)                 sel_idx = lowest(free);
        else if (!lock_i[walk_idx]) sel_idx = walk_idx;
        else                       sel_idx = lowest(unlocked);
    end

    // Later updates overwrite earlier ones on shared nodes: ports in order, refill last
    always_comb begin
        tree_nxt = tree;
        for (int p = 0; p < HIT_PORTS; p++)
            if (hit[p]) tree_nxt = touch(tree_nxt, hit_idx[p]);
        if (state == GRANT && refill_done_i)
            tree_nxt = touch(tree_nxt, victim_idx_o);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            tree            <= '0;
            victim_vld_o    <= 1'b0;
            victim_idx_o    <= '0;
            victim_onehot_o <= '0;
            no_victim_o     <= 1'b0;
        end else begin
            no_victim_o <= 1'b0;
            if (flush_i) begin
                state           <= IDLE;
                tree            <= '0;
                victim_vld_o    <= 1'b0;
                victim_idx_o    <= '0;
                victim_onehot_o <= '0;
            end else begin
                tree <= tree_nxt;
                case (state)
                    IDLE: begin
                        if (alloc_req_i) begin
                            if (any_unlocked) begin
                                state           <= GRANT;
                                victim_vld_o    <= 1'b1;
                                victim_idx_o    <= sel_idx;
                                victim_onehot_o <= ENTRIES'(1) << sel_idx;
                            end else begin
                                no_victim_o <= 1'b1;
                            end
                        end
                    end
                    GRANT: begin
                        if (refill_done_i) begin
                            state           <= IDLE;
                            victim_vld_o    <= 1'b0;
                            victim_idx_o    <= '0;
                            victim_onehot_o <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tlb_plru_alloc.sv
// Directed plus randomized bench for tlb_plru_alloc (8 entries, 2 hit ports) against a
// range-based tree model: a node covers an entry range and points at one half of it.

module tb_tlb_plru_alloc;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  valid = 8'h00;
    logic [7:0]  lock = 8'h00;
    logic [1:0]  hv = 2'b00;
    logic [15:0] hoh = 16'h0000;
    logic        alloc = 1'b0;
    logic        refill = 1'b0;
    logic        victim_vld;
    logic [2:0]  victim_idx;
    logic [7:0]  victim_oh;
    logic        no_victim;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    bit node [7];
    bit mgrant, mvld, mno;
    int midx;

    tlb_plru_alloc #(.ENTRIES(8), .HIT_PORTS(2)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .flush_i         (flush),
        .entry_valid_i   (valid),
        .lock_i          (lock),
        .hit_vld_i       (hv),
        .hit_onehot_i    (hoh),
        .alloc_req_i     (alloc),
        .refill_done_i   (refill),
        .victim_vld_o    (victim_vld),
        .victim_idx_o    (victim_idx),
        .victim_onehot_o (victim_oh),
        .no_victim_o     (no_victim)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Node k sits at level lvl and covers entries [lo, lo+span); it holds 1 when the victim is in the upper half
    function automatic void node_range(input int k, output int lo, output int span);
        int lvl;
        lvl  = $clog2(k + 2) - 1;
        span = 8 >> lvl;
        lo   = (k + 1 - (1 << lvl)) * span;
    endfunction

    function automatic void m_touch(input int e);
        int lo, span;
        for (int k = 0; k < 7; k++) begin
            node_range(k, lo, span);
            if (e >= lo && e < lo + span) node[k] = (e < lo + span/2);
        end
    endfunction

    function automatic int m_walk();
        int lo, span;
        bit ok;
        for (int e = 0; e < 8; e++) begin
            ok = 1'b1;
            for (int k = 0; k < 7; k++) begin
                node_range(k, lo, span);
                if (e >= lo && e < lo + span && node[k] != (e >= lo + span/2)) ok = 1'b0;
            end
            if (ok) return e;
        end
        return -1;
    endfunction

    function automatic int m_victim();
        int w;
        for (int e = 0; e < 8; e++) if (!valid[e] && !lock[e]) return e;
        w = m_walk();
        if (!lock[w]) return w;
        for (int e = 0; e < 8; e++) if (!lock[e]) return e;
        return -1;
    endfunction

    function automatic logic [6:0] m_tree();
        logic [6:0] r;
        for (int k = 0; k < 7; k++) r[k] = node[k];
        return r;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 7; k++) node[k] = 1'b0;
        mgrant = 0; mvld = 0; mno = 0; midx = 0;
    endfunction

    function automatic void m_edge();
        int v;
        logic [7:0] vec;
        v   = m_victim();
        mno = 1'b0;
        if (flush) begin
            for (int k = 0; k < 7; k++) node[k] = 1'b0;
            mgrant = 0; mvld = 0; midx = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                vec = hoh[p*8 +: 8];
                if (hv[p] && $countones(vec) == 1) m_touch($clog2(vec));
            end
            if (mgrant && refill) m_touch(midx);
            if (!mgrant) begin
                if (alloc) begin
                    if (v >= 0) begin mgrant = 1; mvld = 1; midx = v; end
                    else mno = 1;
                end
            end else if (refill) begin
                mgrant = 0; mvld = 0; midx = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check("vld", victim_vld, mvld);
        check("idx", victim_idx, midx);
        check("onehot", victim_oh, mvld ? (32'd1 << midx) : 32'd0);
        check("no_victim", no_victim, mno);
        check("tree", dut.tree, m_tree());
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] gen_vec();
        int r;
        r = $urandom_range(0, 7);
        if (r < 6)       return 8'(1 << $urandom_range(0, 7));
        else if (r == 6) return 8'h00;
        else             return 8'($urandom);
    endfunction

    initial begin
        int r;
        m_reset();
        #12;
        compare_all();
        rstn = 1'b1;

        // invalid-first
        valid = 8'hF7; alloc = 1'b1; step();
        alloc = 1'b0;
        check("inv_first_idx", victim_idx, 3);
        check("inv_first_oh", victim_oh, 8'h08);
        step();
        flush = 1'b1; step(); flush = 1'b0;

        // tree walk after one hit on entry 0
        valid = 8'hFF; hv = 2'b01; hoh = 16'h0001; step();
        hv = 2'b00; alloc = 1'b1; step(); alloc = 1'b0;
        check("walk_idx", victim_idx, 4);
        check("walk_tree", dut.tree, 7'h0B);

        // grant holds through random hits, locks and valids
        for (int i = 0; i < 6; i++) begin
            hv = 2'($urandom); hoh = {gen_vec(), gen_vec()};
            lock = 8'($urandom); valid = 8'($urandom); alloc = 1'($urandom);
            step();
            check("hold_idx", victim_idx, 4);
        end
        lock = 8'h00; valid = 8'hFF; hv = 2'b00; alloc = 1'b0; refill = 1'b1; step(); refill = 1'b0;
        check("refill_vld", victim_vld, 0);
        check("refill_path", {dut.tree[5], dut.tree[2], dut.tree[0]}, 3'b110);
        flush = 1'b1; step(); flush = 1'b0;

        // simultaneous hits on entries 0 and 7
        hv = 2'b11; hoh = {8'h80, 8'h01}; step();
        hv = 2'b00; alloc = 1'b1; step(); alloc = 1'b0;
        check("simul_idx", victim_idx, 2);
        check("simul_tree", dut.tree, 7'h0A);

        // back-to-back allocation right after a refill
        refill = 1'b1; step(); refill = 1'b0;
        alloc = 1'b1; step(); alloc = 1'b0;
        check("b2b_vld", victim_vld, 1);
        flush = 1'b1; step(); flush = 1'b0;

        // lock fallback, flush mid-grant, all locked
        lock = 8'h01; alloc = 1'b1; step();
        check("lock_idx", victim_idx, 1);
        alloc = 1'b0; flush = 1'b1; step(); flush = 1'b0;
        check("flush_vld", victim_vld, 0);
        check("flush_tree", dut.tree, 0);
        lock = 8'hFF; alloc = 1'b1; step();
        check("nv_pulse", no_victim, 1);
        check("nv_vld", victim_vld, 0);
        alloc = 1'b0; step();
        check("nv_clear", no_victim, 0);

        // asynchronous reset in GRANT
        lock = 8'h00; hv = 2'b01; hoh = 16'h0020; step();
        hv = 2'b00; alloc = 1'b1; step(); alloc = 1'b0;
        refill = 1'b1;
        #1 rstn = 1'b0;
        #1;
        m_reset();
        compare_all();
        #1 rstn = 1'b1;
        refill = 1'b0;

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r     = $urandom_range(0, 7);
            lock  = (r < 5) ? 8'h00 : (r < 7) ? 8'($urandom) : 8'hFF;
            valid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            hv    = 2'($urandom);
            hoh   = {gen_vec(), gen_vec()};
            alloc = 1'($urandom);
            refill = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
